// File: rtl/multi_pattern_pwm_if.sv
// Configuration write port of multi_pattern_pwm: write strobe, channel/register select, data and reject flag.
interface multi_pattern_pwm_if;
  localparam int unsigned CH_SEL_W = 3;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned DATA_W   = 16;

  logic                cfg_wr;
  logic [CH_SEL_W-1:0] cfg_ch;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [DATA_W-1:0]   cfg_data;
  logic                cfg_err;

  modport master (output cfg_wr, cfg_ch, cfg_addr, cfg_data, input  cfg_err);
  modport slave  (input  cfg_wr, cfg_ch, cfg_addr, cfg_data, output cfg_err);
endinterface

// File: rtl/multi_pattern_pwm.sv
// N-channel pattern PWM engine with per-channel duty/gap/pulse-count/pattern registers.
// Define MULTI_PWM_SHADOW_EN to buffer writes in shadow registers applied at period boundaries.
module multi_pattern_pwm #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned PAT_WIDTH = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  multi_pattern_pwm_if.slave cfg,
  input  logic [CH_NUM-1:0]  ch_start,
  input  logic [CH_NUM-1:0]  ch_stop,
  output logic [CH_NUM-1:0]  pwm_out,
  output logic [CH_NUM-1:0]  busy,
  output logic [CH_NUM-1:0]  valid
);
  localparam int unsigned DUTY_W = 8;
  localparam int unsigned GAP_W  = 16;
  localparam int unsigned PNUM_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  logic              wr_ok;
  logic [CH_NUM-1:0] wr_busy_hit;
  logic              err_q;
  logic              err_d;

  // Reject flag: out-of-range channel, or (without shadows) a write to a running channel
  assign wr_ok = cfg.cfg_wr && (32'(cfg.cfg_ch) < CH_NUM);
  assign err_d = (cfg.cfg_wr && !wr_ok) || (|wr_busy_hit);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign cfg.cfg_err = err_q;

  for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_ch
    state_t               state_q, state_d;
    logic [DUTY_W-1:0]    duty_q, duty_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [PNUM_W-1:0]    pnum_q, pnum_d;
    logic [PAT_WIDTH-1:0] pat_q, pat_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
    logic [PNUM_W-1:0]    pcnt_q, pcnt_d, pcnt_inc;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pwm_q, pwm_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 wr_sel;
    logic                 start_hit;
    logic                 period_end;
    logic                 enter;

    assign wr_sel = wr_ok && (cfg.cfg_ch == 3'(g));

`ifdef MULTI_PWM_SHADOW_EN
    logic [DUTY_W-1:0]    sh_duty_q;
    logic [GAP_W-1:0]     sh_gap_q;
    logic [PNUM_W-1:0]    sh_pnum_q;
    logic [PAT_WIDTH-1:0] sh_pat_q;

    assign wr_busy_hit[g] = 1'b0;

    // Shadow set accepts writes at any time; consumed on start and period boundaries
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        sh_duty_q <= DUTY_W'(1);
        sh_gap_q  <= GAP_W'(1);
        sh_pnum_q <= '0;
        sh_pat_q  <= PAT_WIDTH'(1);
      end else if (wr_sel) begin
        unique case (cfg.cfg_addr)
          2'd0:    sh_duty_q <= cfg.cfg_data[DUTY_W-1:0];
          2'd1:    sh_gap_q  <= cfg.cfg_data;
          2'd2:    sh_pnum_q <= cfg.cfg_data[PNUM_W-1:0];
          default: sh_pat_q  <= cfg.cfg_data[PAT_WIDTH-1:0];
        endcase
      end
    end
`else
    assign wr_busy_hit[g] = wr_sel && (state_q != S_IDLE);
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        state_q <= S_IDLE;
        duty_q  <= DUTY_W'(1);
        gap_q   <= GAP_W'(1);
        pnum_q  <= '0;
        pat_q   <= PAT_WIDTH'(1);
        idx_q   <= '0;
        pcnt_q  <= '0;
        cnt_q   <= '0;
        pwm_q   <= 1'b0;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        state_q <= state_d;
        duty_q  <= duty_d;
        gap_q   <= gap_d;
        pnum_q  <= pnum_d;
        pat_q   <= pat_d;
        idx_q   <= idx_d;
        pcnt_q  <= pcnt_d;
        cnt_q   <= cnt_d;
        pwm_q   <= pwm_d;
        busy_q  <= busy_d;
        valid_q <= valid_d;
      end
    end

    always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      gap_d      = gap_q;
      pnum_d     = pnum_q;
      pat_d      = pat_q;
      idx_d      = idx_q;
      pcnt_d     = pcnt_q;
      cnt_d      = cnt_q;
      pwm_d      = 1'b0;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      start_hit  = 1'b0;
      period_end = 1'b0;
      enter      = 1'b0;

      idx_inc  = (idx_q == IDX_W'(PAT_WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
      pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + PNUM_W'(1);

      unique case (state_q)
        S_IDLE: begin
          if (ch_start[g] && !ch_stop[g]) begin
            start_hit = 1'b1;
            idx_d     = '0;
            pcnt_d    = '0;
          end
        end
        S_HIGH: begin
          if (17'(cnt_q) + 17'd1 >= 17'(duty_q)) begin
            if (gap_q == '0) begin
              period_end = 1'b1;
            end else begin
              state_d = S_GAP;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          // gap = 0 still occupies one cycle here, giving the one-cycle minimum period
          if (17'(cnt_q) + 17'd1 >= 17'(gap_q)) period_end = 1'b1;
          else                                   cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase

`ifdef MULTI_PWM_SHADOW_EN
      if (start_hit || period_end) begin
        duty_d = sh_duty_q;
        gap_d  = sh_gap_q;
        pnum_d = sh_pnum_q;
        pat_d  = sh_pat_q;
      end
`else
      if (wr_sel && (state_q == S_IDLE)) begin
        unique case (cfg.cfg_addr)
          2'd0:    duty_d = cfg.cfg_data[DUTY_W-1:0];
          2'd1:    gap_d  = cfg.cfg_data;
          2'd2:    pnum_d = cfg.cfg_data[PNUM_W-1:0];
          default: pat_d  = cfg.cfg_data[PAT_WIDTH-1:0];
        endcase
      end
`endif

      // Period boundary: advance pattern, count the pulse, finish or start the next period
      if (period_end) begin
        idx_d  = idx_inc;
        pcnt_d = pcnt_inc;
        if ((pnum_q != '0) && (pcnt_inc == pnum_q)) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
        end else begin
          enter = 1'b1;
        end
      end

      if (start_hit || enter) begin
        cnt_d   = '0;
        state_d = (duty_d != '0) ? S_HIGH : S_GAP;
      end

      if (ch_stop[g]) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
      pwm_d  = (state_d == S_HIGH) && pat_d[idx_d];
    end

    assign pwm_out[g] = pwm_q;
    assign busy[g]    = busy_q;
    assign valid[g]   = valid_q;
  end
endmodule

// File: tb/tb_multi_pattern_pwm.sv
// Directed bench for multi_pattern_pwm (2 channels, 16-bit patterns); honours MULTI_PWM_SHADOW_EN.
module tb_multi_pattern_pwm;
  logic       sys_clk;
  logic       sys_rst;
  logic [1:0] ch_start;
  logic [1:0] ch_stop;
  logic [1:0] pwm_out;
  logic [1:0] busy;
  logic [1:0] valid;
  int         n_checks = 0;
  int         n_pass   = 0;

  multi_pattern_pwm_if cfg_if ();

  multi_pattern_pwm #(.CH_NUM(2), .PAT_WIDTH(16)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cfg      (cfg_if.slave),
    .ch_start (ch_start),
    .ch_stop  (ch_stop),
    .pwm_out  (pwm_out),
    .busy     (busy),
    .valid    (valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [1:0] addr, input logic [15:0] data);
    cfg_if.cfg_wr   = 1'b1;
    cfg_if.cfg_ch   = ch;
    cfg_if.cfg_addr = addr;
    cfg_if.cfg_data = data;
    tick();
    cfg_if.cfg_wr   = 1'b0;
  endtask

  task automatic start(input logic [1:0] m);
    ch_start = m;
    tick();
    ch_start = 2'b00;
  endtask

  task automatic stop(input logic [1:0] m);
    ch_stop = m;
    tick();
    ch_stop = 2'b00;
  endtask

  initial begin
    int          hi;
    int          mism;
    logic [7:0]  samp;
    logic [15:0] pat_a;
    logic        exp_bit;

    sys_rst         = 1'b1;
    ch_start        = 2'b00;
    ch_stop         = 2'b00;
    cfg_if.cfg_wr   = 1'b0;
    cfg_if.cfg_ch   = 3'd0;
    cfg_if.cfg_addr = 2'd0;
    cfg_if.cfg_data = 16'd0;

    repeat (2) tick();
    check("rst_pwm",   32'(pwm_out), 32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_valid", 32'(valid),   32'd0);
    check("rst_err",   32'(cfg_if.cfg_err), 32'd0);
    #3 sys_rst = 1'b0;
    tick();

    // Defaults: duty 1, gap 1, PAT = 1 -> only pattern bit 0 drives high
    start(2'b01);
    check("t1_first_high", 32'(pwm_out[0]), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_gap_low", 32'(pwm_out[0]), 32'd0);
    tick();
    check("t1_pat_bit1_low", 32'(pwm_out[0]), 32'd0);
    stop(2'b01);
    check("t1_stop_pwm",  32'(pwm_out[0]), 32'd0);
    check("t1_stop_busy", 32'(busy[0]),    32'd0);
    check("t1_stop_valid", 32'(valid[0]),  32'd0);

    cfg_write(3'd0, 2'd3, 16'hFFFF);
    check("t1_idle_wr_err", 32'(cfg_if.cfg_err), 32'd0);
    start(2'b01);
    samp = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      samp[k] = pwm_out[0];
    end
    check("t1_alternate", 32'(samp), 32'h55);
    stop(2'b01);
    check("t1_stop2_pwm", 32'(pwm_out[0]), 32'd0);
    tick();
    check("t1_no_valid", 32'(valid), 32'd0);

    cfg_write(3'd5, 2'd0, 16'd7);
    check("oor_err", 32'(cfg_if.cfg_err), 32'd1);
    tick();
    check("oor_err_pulse", 32'(cfg_if.cfg_err), 32'd0);

    // ch1: 10 high + 90 low, then a silent period (PAT bit1 = 0), two pulses total
    cfg_write(3'd1, 2'd0, 16'd10);
    cfg_write(3'd1, 2'd1, 16'd90);
    cfg_write(3'd1, 2'd2, 16'd2);
    start(2'b10);
    hi = 0;
    for (int k = 0; k <= 201; k++) begin
      if (k > 0) tick();
      if (k < 200) hi += int'(pwm_out[1]);
      if (k == 0)  check("t2_first_high", 32'(pwm_out[1]), 32'd1);
      if (k == 9)  check("t2_last_high",  32'(pwm_out[1]), 32'd1);
      if (k == 10) check("t2_gap_start",  32'(pwm_out[1]), 32'd0);
      if (k == 100) check("t2_pat1_low",  32'(pwm_out[1]), 32'd0);
      if (k == 199) begin
        check("t2_busy_before", 32'(busy[1]),  32'd1);
        check("t2_valid_early", 32'(valid[1]), 32'd0);
      end
      if (k == 200) begin
        check("t2_valid",     32'(valid[1]), 32'd1);
        check("t2_busy_fall", 32'(busy[1]),  32'd0);
      end
      if (k == 201) check("t2_valid_1cyc", 32'(valid[1]), 32'd0);
    end
    check("t2_high_count", 32'(hi), 32'd10);

    // ch1: pattern A5A5, 2+2 period, 20 pulses -> wraps after bit 15
    pat_a = 16'hA5A5;
    cfg_write(3'd1, 2'd3, pat_a);
    cfg_write(3'd1, 2'd0, 16'd2);
    cfg_write(3'd1, 2'd1, 16'd2);
    cfg_write(3'd1, 2'd2, 16'd20);
    start(2'b10);
    mism = 0;
    for (int k = 0; k <= 81; k++) begin
      if (k > 0) tick();
      if (k < 80) begin
        exp_bit = ((k % 4) < 2) ? pat_a[(k / 4) % 16] : 1'b0;
        if (pwm_out[1] !== exp_bit) mism++;
      end
      if (k == 64) check("t3_wrap_bit0", 32'(pwm_out[1]), 32'd1);
      if (k == 68) check("t3_wrap_bit1", 32'(pwm_out[1]), 32'd0);
      if (k == 79) check("t3_valid_early", 32'(valid[1]), 32'd0);
      if (k == 80) begin
        check("t3_valid",     32'(valid[1]), 32'd1);
        check("t3_busy_fall", 32'(busy[1]),  32'd0);
      end
    end
    check("t3_pattern_mism", 32'(mism), 32'd0);

    // Multi-channel launch and start/stop collision
    check("t4_idle_pwm", 32'(pwm_out), 32'd0);
    start(2'b11);
    check("t4_aligned_pwm",  32'(pwm_out), 32'd3);
    check("t4_aligned_busy", 32'(busy),    32'd3);
    stop(2'b11);
    check("t4_stop_all", 32'(busy), 32'd0);
    ch_start = 2'b01;
    ch_stop  = 2'b01;
    tick();
    ch_start = 2'b00;
    ch_stop  = 2'b00;
    check("t4_collide_busy", 32'(busy[0]),    32'd0);
    check("t4_collide_pwm",  32'(pwm_out[0]), 32'd0);
    tick();
    check("t4_collide_stay", 32'(busy[0]), 32'd0);

    // Duty write to running ch0 (duty 1, gap 1, PAT FFFF)
    start(2'b01);
    cfg_write(3'd0, 2'd0, 16'd5);
`ifdef MULTI_PWM_SHADOW_EN
    check("t5_busy_wr_err", 32'(cfg_if.cfg_err), 32'd0);
`else
    check("t5_busy_wr_err", 32'(cfg_if.cfg_err), 32'd1);
`endif
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      hi += int'(pwm_out[0]);
      if (k == 0) check("t5_err_pulse", 32'(cfg_if.cfg_err), 32'd0);
`ifdef MULTI_PWM_SHADOW_EN
      if (k == 1) check("t5_second_cycle", 32'(pwm_out[0]), 32'd1);
`else
      if (k == 1) check("t5_second_cycle", 32'(pwm_out[0]), 32'd0);
`endif
    end
`ifdef MULTI_PWM_SHADOW_EN
    check("t5_high_count", 32'(hi), 32'd5);
`else
    check("t5_high_count", 32'(hi), 32'd3);
`endif
    stop(2'b01);

    // Asynchronous reset in the middle of a HIGH phase
    cfg_write(3'd1, 2'd0, 16'd10);
    start(2'b10);
    repeat (3) tick();
    check("t6_mid_high", 32'(pwm_out[1]), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("t6_async_pwm",   32'(pwm_out), 32'd0);
    check("t6_async_busy",  32'(busy),    32'd0);
    check("t6_async_valid", 32'(valid),   32'd0);
    tick();
    #3 sys_rst = 1'b0;
    tick();
    start(2'b10);
    check("t6_def_pat0", 32'(pwm_out[1]), 32'd1);
    tick();
    check("t6_def_duty", 32'(pwm_out[1]), 32'd0);
    tick();
    check("t6_def_pat1", 32'(pwm_out[1]), 32'd0);
    check("t6_def_pnum", 32'(busy[1]),    32'd1);
    stop(2'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
